// File: rtl/eh2_acc_pkg.sv
// Shared types and constants for the EH2 access-region checker.
// Optional top-of-range matching is enabled by EH2_ACCESS_REGION_TOR_EN.
package eh2_acc_pkg;

    typedef struct packed {
        logic       lock;
        logic [1:0] rsvd;
        logic       mode;
        logic       x;
        logic       w;
        logic       r;
        logic       en;
    } eh2_acc_ctrl_t;

    typedef enum logic [1:0] {
        ACC_SEL_BASE = 2'd0,
        ACC_SEL_MASK = 2'd1,
        ACC_SEL_CTRL = 2'd2,
        ACC_SEL_RSVD = 2'd3
    } eh2_acc_sel_e;

    typedef enum logic [1:0] {
        ACC_KIND_READ  = 2'd0,
        ACC_KIND_WRITE = 2'd1,
        ACC_KIND_FETCH = 2'd2,
        ACC_KIND_RSVD  = 2'd3
    } eh2_acc_kind_e;

    localparam eh2_acc_ctrl_t ACC_CTRL_RST = '0;

    // Only implemented ctrl bits are stored; mode exists only with TOR support.
`ifdef EH2_ACCESS_REGION_TOR_EN
    localparam logic [7:0] ACC_CTRL_WMASK = 8'h9F;
`else
    localparam logic [7:0] ACC_CTRL_WMASK = 8'h8F;
`endif

    function automatic eh2_acc_ctrl_t acc_ctrl_pack(input logic [7:0] wdata);
        return eh2_acc_ctrl_t'(wdata & ACC_CTRL_WMASK);
    endfunction

endpackage

// File: rtl/eh2_acc_region_match.sv
// Combinational single-region address comparator (NAPOT, plus TOR when
// EH2_ACCESS_REGION_TOR_EN is defined).
module eh2_acc_region_match
    import eh2_acc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    input  logic [ADDR_W-1:0] prev_base,
    input  eh2_acc_ctrl_t     ctrl,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);

    logic napot_s;
    assign napot_s = ((addr | mask) == (base | mask));

`ifdef EH2_ACCESS_REGION_TOR_EN
    logic tor_s;
    logic unused_ctrl_s;
    assign tor_s         = (addr >= prev_base) && (addr < base);
    assign hit           = ctrl.en && (ctrl.mode ? tor_s : napot_s);
    assign unused_ctrl_s = ^{ctrl.lock, ctrl.rsvd, ctrl.x, ctrl.w, ctrl.r};
`else
    logic unused_ctrl_s;
    assign hit           = ctrl.en && napot_s;
    assign unused_ctrl_s = ^{prev_base, ctrl.lock, ctrl.rsvd, ctrl.mode, ctrl.x, ctrl.w, ctrl.r};
`endif

endmodule

// File: rtl/eh2_access_region_ctl.sv
// Runtime-programmable access-region checker with one-stage pipelined checks
// and first-violation capture. TOR matching via EH2_ACCESS_REGION_TOR_EN.
module eh2_access_region_ctl
    import eh2_acc_pkg::*;
#(
    parameter  int NUM_REGIONS = 8,
    parameter  int ADDR_W      = 32,
    localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_wdata,
    output logic [ADDR_W-1:0] cfg_rdata,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_kind,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_region,
    output logic              viol_valid,
    output logic [ADDR_W-1:0] viol_addr,
    output logic              viol_ovf,
    input  logic              viol_clr
);

    logic [ADDR_W-1:0] base_r [NUM_REGIONS];
    logic [ADDR_W-1:0] mask_r [NUM_REGIONS];
    eh2_acc_ctrl_t     ctrl_r [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] hit_s;
    logic [NUM_REGIONS-1:0] en_s;
    logic                   idx_ok_s;
    logic [ADDR_W-1:0]      rdata_s;
    logic [7:0]             ctrl_rd_s;
    logic                   any_hit_s;
    logic                   any_en_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic                   perm_s;
    logic                   err_s;
    logic                   accept_s;
    logic                   ready_en_r;
    logic [ADDR_W-1:0]      rsp_addr_r;

    assign idx_ok_s  = (32'(cfg_idx) < NUM_REGIONS);
    assign ctrl_rd_s = ctrl_r[cfg_idx];
    assign req_ready = ready_en_r && (!rsp_valid || rsp_ready);
    assign accept_s  = req_valid && req_ready;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        logic [ADDR_W-1:0] prev_base_s;
        if (g == 0) begin : g_first
            assign prev_base_s = '0;
        end else begin : g_rest
            assign prev_base_s = base_r[g-1];
        end
        assign en_s[g] = ctrl_r[g].en;
        eh2_acc_region_match #(.ADDR_W(ADDR_W)) u_match (
            .base      (base_r[g]),
            .mask      (mask_r[g]),
            .prev_base (prev_base_s),
            .ctrl      (ctrl_r[g]),
            .addr      (req_addr),
            .hit       (hit_s[g])
        );
    end

    // Config register writes; a locked region ignores all writes until reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_r[i] <= '0;
                mask_r[i] <= '0;
                ctrl_r[i] <= ACC_CTRL_RST;
            end
        end else if (cfg_we && idx_ok_s && !ctrl_r[cfg_idx].lock) begin
            case (eh2_acc_sel_e'(cfg_sel))
                ACC_SEL_BASE: base_r[cfg_idx] <= cfg_wdata;
                ACC_SEL_MASK: mask_r[cfg_idx] <= cfg_wdata;
                ACC_SEL_CTRL: ctrl_r[cfg_idx] <= acc_ctrl_pack(cfg_wdata[7:0]);
                default: ;
            endcase
        end
    end

    // Readback selection for the registered cfg_rdata port.
    always_comb begin
        rdata_s = '0;
        if (idx_ok_s) begin
            case (eh2_acc_sel_e'(cfg_sel))
                ACC_SEL_BASE: rdata_s = base_r[cfg_idx];
                ACC_SEL_MASK: rdata_s = mask_r[cfg_idx];
                ACC_SEL_CTRL: rdata_s = ADDR_W'(ctrl_rd_s);
                default:      rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    // Registered readback.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cfg_rdata <= '0;
        end else begin
            cfg_rdata <= rdata_s;
        end
    end

    // Priority encoder: scanning downward leaves the lowest hit selected.
    always_comb begin
        any_hit_s = |hit_s;
        any_en_s  = |en_s;
        sel_idx_s = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            sel_idx_s = hit_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end

    // Access decision from the winning region's permissions.
    always_comb begin
        perm_s = 1'b0;
        err_s  = 1'b0;
        case (eh2_acc_kind_e'(req_kind))
            ACC_KIND_READ:  perm_s = ctrl_r[sel_idx_s].r;
            ACC_KIND_WRITE: perm_s = ctrl_r[sel_idx_s].w;
            ACC_KIND_FETCH: perm_s = ctrl_r[sel_idx_s].x;
            default:        perm_s = 1'b0;
        endcase
        if (eh2_acc_kind_e'(req_kind) == ACC_KIND_RSVD) begin
            err_s = 1'b1;
        end else if (!any_en_s) begin
            err_s = 1'b0;
        end else if (!any_hit_s) begin
            err_s = 1'b1;
        end else begin
            err_s = !perm_s;
        end
    end

    // Single response stage; fields hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ready_en_r <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_region <= '0;
            rsp_addr_r <= '0;
        end else begin
            ready_en_r <= 1'b1;
            if (accept_s) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= err_s;
                rsp_hit    <= any_hit_s;
                rsp_region <= sel_idx_s;
                rsp_addr_r <= req_addr;
            end else if (rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    // First-violation capture; a same-cycle clear loses to a new violation.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            viol_valid <= 1'b0;
            viol_addr  <= '0;
            viol_ovf   <= 1'b0;
        end else if (rsp_valid && rsp_ready && rsp_err) begin
            if (!viol_valid || viol_clr) begin
                viol_valid <= 1'b1;
                viol_addr  <= rsp_addr_r;
                viol_ovf   <= 1'b0;
            end else begin
                viol_ovf   <= 1'b1;
            end
        end else if (viol_clr) begin
            viol_valid <= 1'b0;
            viol_ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eh2_access_region_ctl.sv
// Directed self-checking bench for eh2_access_region_ctl (8 regions, 32-bit);
// the TOR case runs only when EH2_ACCESS_REGION_TOR_EN is defined.
module tb_eh2_access_region_ctl;

    logic        clk;
    logic        rst_l;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_kind;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic        rsp_hit;
    logic [2:0]  rsp_region;
    logic        viol_valid;
    logic [31:0] viol_addr;
    logic        viol_ovf;
    logic        viol_clr;

    int n_checks;
    int n_pass;

    eh2_access_region_ctl #(.NUM_REGIONS(8), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_kind   (req_kind),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_err    (rsp_err),
        .rsp_hit    (rsp_hit),
        .rsp_region (rsp_region),
        .viol_valid (viol_valid),
        .viol_addr  (viol_addr),
        .viol_ovf   (viol_ovf),
        .viol_clr   (viol_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_sel   = sel;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read_chk(input string tag, input logic [2:0] idx, input logic [1:0] sel,
                                input logic [31:0] exp);
        @(negedge clk);
        cfg_idx = idx;
        cfg_sel = sel;
        @(negedge clk);
        chk_eq(tag, cfg_rdata, exp);
    endtask

    // One request with an always-ready consumer: response one cycle after acceptance.
    task automatic req_chk(input string tag, input logic [31:0] addr, input logic [1:0] kind,
                           input logic exp_err, input logic exp_hit, input logic [2:0] exp_reg);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_kind  = kind;
        rsp_ready = 1'b1;
        #1;
        chk_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk_eq({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        chk_eq({tag, ".hit"}, 32'(rsp_hit), 32'(exp_hit));
        chk_eq({tag, ".region"}, 32'(rsp_region), 32'(exp_reg));
        @(negedge clk);
        chk_eq({tag, ".drain"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic viol_chk(input string tag, input logic exp_v, input logic [31:0] exp_a,
                            input logic exp_o);
        chk_eq({tag, ".viol_valid"}, 32'(viol_valid), 32'(exp_v));
        chk_eq({tag, ".viol_addr"}, viol_addr, exp_a);
        chk_eq({tag, ".viol_ovf"}, 32'(viol_ovf), 32'(exp_o));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_l     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = 3'd0;
        cfg_sel   = 2'd0;
        cfg_wdata = 32'd0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_kind  = 2'd0;
        rsp_ready = 1'b0;
        viol_clr  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst.req_ready", 32'(req_ready), 32'd0);
        viol_chk("rst", 1'b0, 32'd0, 1'b0);
        rst_l = 1'b1;
        @(negedge clk);
        chk_eq("rst.ready_after", 32'(req_ready), 32'd1);
        chk_eq("rst.cfg_rdata", cfg_rdata, 32'd0);

        // Nothing enabled: everything allowed
        req_chk("nocfg", 32'h1234_5678, 2'd0, 1'b0, 1'b0, 3'd0);

        // Region 2 NAPOT, read-only
        cfg_write(3'd2, 2'd0, 32'hF004_0000);
        cfg_write(3'd2, 2'd1, 32'h0000_FFFF);
        cfg_write(3'd2, 2'd2, 32'h0000_0003);
        cfg_read_chk("r2.base_rd", 3'd2, 2'd0, 32'hF004_0000);
        cfg_read_chk("r2.ctrl_rd", 3'd2, 2'd2, 32'h0000_0003);
        req_chk("r2.read", 32'hF004_1000, 2'd0, 1'b0, 1'b1, 3'd2);
        viol_chk("r2.read", 1'b0, 32'd0, 1'b0);
        req_chk("r2.write", 32'hF004_1000, 2'd1, 1'b1, 1'b1, 3'd2);
        viol_chk("r2.write", 1'b1, 32'hF004_1000, 1'b0);
        req_chk("r2.fetch", 32'hF004_1000, 2'd2, 1'b1, 1'b1, 3'd2);
        viol_chk("r2.fetch", 1'b1, 32'hF004_1000, 1'b1);
        req_chk("r2.miss", 32'hF005_0000, 2'd0, 1'b1, 1'b0, 3'd0);
        viol_chk("r2.miss", 1'b1, 32'hF004_1000, 1'b1);

        @(negedge clk);
        viol_clr = 1'b1;
        @(negedge clk);
        viol_clr = 1'b0;
        chk_eq("clr.viol_valid", 32'(viol_valid), 32'd0);
        chk_eq("clr.viol_ovf", 32'(viol_ovf), 32'd0);

        // Overlapping regions 1 (R) and 3 (RWX): lowest index decides
        cfg_write(3'd1, 2'd0, 32'h8000_0000);
        cfg_write(3'd1, 2'd1, 32'h0000_0FFF);
        cfg_write(3'd1, 2'd2, 32'h0000_0003);
        cfg_write(3'd3, 2'd0, 32'h8000_0000);
        cfg_write(3'd3, 2'd1, 32'h0FFF_FFFF);
        cfg_write(3'd3, 2'd2, 32'h0000_000F);
        req_chk("prio.w", 32'h8000_0000, 2'd1, 1'b1, 1'b1, 3'd1);
        viol_chk("prio.w", 1'b1, 32'h8000_0000, 1'b0);
        req_chk("prio.r3", 32'h8000_1000, 2'd1, 1'b0, 1'b1, 3'd3);
        req_chk("kind3", 32'h8000_1000, 2'd3, 1'b1, 1'b1, 3'd3);
        viol_chk("kind3", 1'b1, 32'h8000_0000, 1'b1);

        // Lock region 0, then attempt writes
        cfg_write(3'd0, 2'd2, 32'h0000_0083);
        cfg_write(3'd0, 2'd0, 32'hDEAD_0000);
        cfg_write(3'd0, 2'd2, 32'h0000_0000);
        cfg_read_chk("lock.base", 3'd0, 2'd0, 32'h0000_0000);
        cfg_read_chk("lock.ctrl", 3'd0, 2'd2, 32'h0000_0083);

        // Reserved select and unstored ctrl bits
        cfg_write(3'd4, 2'd3, 32'hFFFF_FFFF);
        cfg_read_chk("rsvd.sel", 3'd4, 2'd3, 32'h0000_0000);
`ifndef EH2_ACCESS_REGION_TOR_EN
        cfg_write(3'd4, 2'd2, 32'h0000_0073);
        cfg_read_chk("rsvd.mode", 3'd4, 2'd2, 32'h0000_0003);
`endif

        // Backpressure: three stalled cycles, then drain with clear+new error
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'hF004_1000;
        req_kind  = 2'd0;
        rsp_ready = 1'b0;
        #1;
        chk_eq("bp.ready0", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_addr = 32'h8000_0004;
            req_kind = 2'd1;
            #1;
            chk_eq("bp.stall_ready", 32'(req_ready), 32'd0);
            chk_eq("bp.stall_valid", 32'(rsp_valid), 32'd1);
            chk_eq("bp.stall_err", 32'(rsp_err), 32'd0);
            chk_eq("bp.stall_region", 32'(rsp_region), 32'd2);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk_eq("bp.release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        viol_clr  = 1'b1;
        chk_eq("bp.second_valid", 32'(rsp_valid), 32'd1);
        chk_eq("bp.second_err", 32'(rsp_err), 32'd1);
        chk_eq("bp.second_region", 32'(rsp_region), 32'd1);
        @(negedge clk);
        viol_clr = 1'b0;
        chk_eq("bp.drain", 32'(rsp_valid), 32'd0);
        viol_chk("clrwin", 1'b1, 32'h8000_0004, 1'b0);

        // Reset mid-operation drops the response and clears locks
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'hF004_1000;
        req_kind  = 2'd1;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk_eq("mid.inflight", 32'(rsp_valid), 32'd1);
        rst_l = 1'b0;
        #1;
        chk_eq("mid.rsp_dropped", 32'(rsp_valid), 32'd0);
        viol_chk("mid", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst_l     = 1'b1;
        rsp_ready = 1'b1;
        cfg_read_chk("mid.base2", 3'd2, 2'd0, 32'h0000_0000);
        cfg_read_chk("mid.ctrl0", 3'd0, 2'd2, 32'h0000_0000);
        cfg_write(3'd0, 2'd0, 32'hDEAD_0000);
        cfg_read_chk("mid.unlocked", 3'd0, 2'd0, 32'hDEAD_0000);

`ifdef EH2_ACCESS_REGION_TOR_EN
        // Top-of-range: region 1 covers [base0, base1)
        cfg_write(3'd0, 2'd0, 32'h0000_1000);
        cfg_write(3'd1, 2'd0, 32'h0000_2000);
        cfg_write(3'd1, 2'd2, 32'h0000_0019);
        cfg_read_chk("tor.ctrl", 3'd1, 2'd2, 32'h0000_0019);
        req_chk("tor.in", 32'h0000_1FFC, 2'd2, 1'b0, 1'b1, 3'd1);
        req_chk("tor.top", 32'h0000_2000, 2'd2, 1'b1, 1'b0, 3'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
